dsm_decim_chain: RTL and testbench



---
 rtl/dsm_decim_chain_pkg.sv | 28 ++
 rtl/dsm_decim_chain_hbf_decim2.sv | 76 +++++++
 rtl/dsm_decim_chain.sv | 100 ++++++++++
 tb/tb_dsm_decim_chain.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dsm_decim_chain_pkg.sv
// rtl/dsm_decim_chain_pkg.sv - shared constants for the DSM decimation chain
package dsm_decim_chain_pkg;

  localparam int CIC_R_DEF = 16;
  localparam int CIC_N_DEF = 5;

  localparam int COEF_W    = 16;
  localparam int HBF1_TAPS = 7;
  localparam int HBF2_TAPS = 11;

  localparam logic [HBF1_TAPS-1:0][COEF_W-1:0] HBF1_COEF = {
    -16'sd1, 16'sd0, 16'sd9, 16'sd16, 16'sd9, 16'sd0, -16'sd1
  };

  localparam logic [HBF2_TAPS-1:0][COEF_W-1:0] HBF2_COEF = {
    16'sd3, 16'sd0, -16'sd25, 16'sd0, 16'sd150, 16'sd256,
    16'sd150, 16'sd0, -16'sd25, 16'sd0, 16'sd3
  };

  localparam int HBF1_SHIFT = 5;
  localparam int HBF2_SHIFT = 9;

  // Worst-case growth is bounded by the sum of |coefficients|, plus a sign bit.
  function automatic int hbf_acc_width(input int in_w, input int coef_abs_sum);
    return in_w + $clog2(coef_abs_sum) + 1;
  endfunction

endpackage

// File: rtl/dsm_decim_chain_hbf_decim2.sv
// rtl/dsm_decim_chain_hbf_decim2.sv - halfband FIR, decimate by 2
module hbf_decim2
  import dsm_decim_chain_pkg::*;
#(
  parameter int                          DW    = 33,
  parameter int                          TAPS  = 7,
  parameter logic [TAPS-1:0][COEF_W-1:0] COEF  = '0,
  parameter int                          SHIFT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic signed [DW-1:0] i_data,
  output logic                 o_valid,
  output logic signed [DW-1:0] o_data
);

  function automatic int coef_abs_sum();
    int s;
    s = 0;
    for (int i = 0; i < TAPS; i++) begin
      int c;
      c = int'($signed(COEF[i]));
      s += (c < 0) ? -c : c;
    end
    return s;
  endfunction

  localparam int ACC_W = hbf_acc_width(DW, coef_abs_sum());

  logic signed [DW-1:0]    r_dl [TAPS-1];
  logic                    r_phase;
  logic                    r_valid;
  logic signed [DW-1:0]    r_data;
  logic signed [DW-1:0]    w_win [TAPS];
  logic signed [ACC_W-1:0] w_acc;

  // Window includes the incoming sample so the result lands one clk after it.
  always_comb begin
    w_win[0] = i_data;
    for (int i = 1; i < TAPS; i++) begin
      w_win[i] = r_dl[i-1];
    end
    w_acc = '0;
    for (int i = 0; i < TAPS; i++) begin
      w_acc = w_acc + ACC_W'(w_win[i]) * ACC_W'($signed(COEF[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS - 1; i++) begin
        r_dl[i] <= '0;
      end
      r_phase <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid && r_phase;
      if (i_valid) begin
        r_dl[0] <= i_data;
        for (int i = 1; i < TAPS - 1; i++) begin
          r_dl[i] <= r_dl[i-1];
        end
        r_phase <= ~r_phase;
        if (r_phase) begin
          r_data <= DW'(w_acc >>> SHIFT);
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/dsm_decim_chain.sv
// rtl/dsm_decim_chain.sv - CIC decimator followed by two halfband decimate-by-2 stages
module dsm_decim_chain
  import dsm_decim_chain_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int CIC_R = CIC_R_DEF,
  parameter int CIC_N = CIC_N_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [1:0]     in,
  output logic signed [SIZE:0]  out,
  output logic                  out_valid
);

  localparam int CNT_W = (CIC_R > 1) ? $clog2(CIC_R) : 1;

  logic [CNT_W-1:0]       r_cnt;
  logic signed [SIZE-1:0] r_integ [CIC_N];
  logic signed [SIZE-1:0] r_samp;
  logic                   r_samp_vld;
  logic signed [SIZE-1:0] r_comb_dly [CIC_N];
  logic signed [SIZE:0]   r_cic_data;
  logic                   r_cic_valid;
  logic signed [SIZE-1:0] w_comb [CIC_N+1];
  logic                   w_last;

  logic                   w_hb1_valid;
  logic signed [SIZE:0]   w_hb1_data;

  assign w_last = (r_cnt == CNT_W'(CIC_R - 1));

  always_comb begin
    w_comb[0] = r_samp;
    for (int k = 0; k < CIC_N; k++) begin
      w_comb[k+1] = w_comb[k] - r_comb_dly[k];
    end
  end

  // Integrators wrap freely; the comb differences recover the exact result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_samp      <= '0;
      r_samp_vld  <= 1'b0;
      r_cic_data  <= '0;
      r_cic_valid <= 1'b0;
      for (int k = 0; k < CIC_N; k++) begin
        r_integ[k]    <= '0;
        r_comb_dly[k] <= '0;
      end
    end else begin
      r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
      r_integ[0] <= r_integ[0] + SIZE'(in);
      for (int k = 1; k < CIC_N; k++) begin
        r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
      r_samp_vld <= w_last;
      if (w_last) begin
        r_samp <= r_integ[CIC_N-1];
      end
      r_cic_valid <= r_samp_vld;
      if (r_samp_vld) begin
        for (int k = 0; k < CIC_N; k++) begin
          r_comb_dly[k] <= w_comb[k];
        end
        r_cic_data <= (SIZE+1)'(w_comb[CIC_N]);
      end
    end
  end

  hbf_decim2 #(
    .DW    (SIZE + 1),
    .TAPS  (HBF1_TAPS),
    .COEF  (HBF1_COEF),
    .SHIFT (HBF1_SHIFT)
  ) u_hbf1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_cic_valid),
    .i_data  (r_cic_data),
    .o_valid (w_hb1_valid),
    .o_data  (w_hb1_data)
  );

  hbf_decim2 #(
    .DW    (SIZE + 1),
    .TAPS  (HBF2_TAPS),
    .COEF  (HBF2_COEF),
    .SHIFT (HBF2_SHIFT)
  ) u_hbf2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_hb1_valid),
    .i_data  (w_hb1_data),
    .o_valid (out_valid),
    .o_data  (out)
  );

endmodule

// File: tb/tb_dsm_decim_chain.sv
// tb/tb_dsm_decim_chain.sv - scoreboard bench for dsm_decim_chain
module tb_dsm_decim_chain;

  localparam int     SIZE  = 32;
  localparam int     R     = 16;
  localparam int     N     = 5;
  localparam int     DEC   = 4 * R;
  localparam longint ONE_G = 1048576;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [1:0]    r_in = '0;
  logic signed [SIZE:0] w_out;
  logic                 w_out_valid;

  dsm_decim_chain #(.SIZE(SIZE), .CIC_R(R), .CIC_N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (r_in),
    .out       (w_out),
    .out_valid (w_out_valid)
  );

  always #2 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     edge_idx = 0;
  int     last_pulse = 0;
  int     pulse_cnt = 0;
  bit     mon_en = 1'b0;
  longint hold_exp = 0;

  longint h_cic[$];
  longint x_hist[$];
  longint cic_y[$];
  longint hb1_y[$];
  longint exp_q[$];
  longint c1[7]  = '{-1, 0, 9, 16, 9, 0, -1};
  longint c2[11] = '{3, 0, -25, 0, 150, 256, 150, 0, -25, 0, 3};

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // CIC impulse response: N-fold convolution of a length-R boxcar.
  function automatic void build_cic();
    longint cur[$];
    longint nxt[$];
    cur.push_back(1);
    for (int s = 0; s < N; s++) begin
      nxt.delete();
      for (int i = 0; i < cur.size() + R - 1; i++) nxt.push_back(0);
      for (int i = 0; i < cur.size(); i++)
        for (int j = 0; j < R; j++) nxt[i+j] += cur[i];
      cur = nxt;
    end
    h_cic = cur;
  endfunction

  function automatic longint xat(input int e);
    if (e >= 1 && e <= x_hist.size()) return x_hist[e-1];
    return 0;
  endfunction

  function automatic longint cat(input int k);
    if (k >= 1 && k <= cic_y.size()) return cic_y[k-1];
    return 0;
  endfunction

  function automatic longint h1at(input int p);
    if (p >= 1 && p <= hb1_y.size()) return hb1_y[p-1];
    return 0;
  endfunction

  // CIC sample k sees inputs up to edge k*R-N; halfbands keep every 2nd output.
  function automatic void model_advance();
    int     m;
    longint acc;
    m = x_hist.size() / DEC;
    while (cic_y.size() < 4 * m) begin
      int k;
      k = cic_y.size() + 1;
      acc = 0;
      for (int i = 0; i < h_cic.size(); i++) acc += h_cic[i] * xat(k * R - N - i);
      cic_y.push_back(acc);
    end
    while (hb1_y.size() < 2 * m) begin
      int p;
      p = hb1_y.size() + 1;
      acc = 0;
      for (int i = 0; i < 7; i++) acc += c1[i] * cat(2 * p - i);
      hb1_y.push_back(acc >>> 5);
    end
    acc = 0;
    for (int j = 0; j < 11; j++) acc += c2[j] * h1at(2 * m - j);
    exp_q.push_back(acc >>> 9);
  endfunction

  task automatic step(input logic rv, input logic signed [1:0] x);
    rst  = rv;
    r_in = x;
    @(posedge clk);
    #1;
    if (rv) begin
      x_hist.delete();
      cic_y.delete();
      hb1_y.delete();
      exp_q.delete();
      edge_idx   = 0;
      last_pulse = 0;
      hold_exp   = 0;
    end else begin
      edge_idx++;
      x_hist.push_back(longint'(x));
      if (x_hist.size() % DEC == 0) model_advance();
    end
  endtask

  task automatic reset_dut();
    repeat (2) step(1'b1, 2'sd0);
    pulse_cnt = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (w_out_valid) begin
        pulse_cnt++;
        if (last_pulse == 0) check("first_pulse_latency", edge_idx, DEC + 3);
        else check("pulse_spacing", edge_idx - last_pulse, DEC);
        last_pulse = edge_idx;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_unexpected: got %0d with no expected sample queued", w_out);
        end else begin
          hold_exp = exp_q.pop_front();
          check("out_value", w_out, hold_exp);
        end
      end else begin
        check("out_hold", w_out, hold_exp);
      end
    end
  end

  initial begin
    build_cic();
    repeat (3) step(1'b1, 2'sd0);
    mon_en = 1'b1;
    check("reset_out", w_out, 0);
    check("reset_out_valid", w_out_valid, 0);

    // Impulse
    step(1'b0, 2'sd1);
    repeat (16 * DEC - 1) step(1'b0, 2'sd0);
    check("impulse_tail", w_out, 0);

    // Random legal inputs including -2
    reset_dut();
    repeat (1500) step(1'b0, 2'($urandom_range(0, 3)));

    // Constant +1, then a one-clk reset mid-stream
    reset_dut();
    repeat (2000) step(1'b0, 2'sd1);
    check("const_pos", w_out, ONE_G);
    repeat (37) step(1'b0, 2'sd1);
    step(1'b1, 2'sd1);
    check("midrst_out", w_out, 0);
    check("midrst_out_valid", w_out_valid, 0);
    repeat (1000) step(1'b0, 2'sd1);
    check("reconverge", w_out, ONE_G);

    // Constant -1
    reset_dut();
    repeat (2000) step(1'b0, -2'sd1);
    check("const_neg", w_out, -ONE_G);

    // Alternating +1/-1
    reset_dut();
    for (int i = 0; i < 2000; i++) step(1'b0, (i % 2 != 0) ? -2'sd1 : 2'sd1);
    check("alternating", w_out, 0);

    // Pulse count over 6400 inputs plus pipeline drain
    reset_dut();
    repeat (6400) step(1'b0, 2'($urandom_range(0, 3)));
    repeat (20) step(1'b0, 2'($urandom_range(0, 3)));
    check("pulse_count", pulse_cnt, 100);
    check("queue_drained", exp_q.size(), 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
